dw_word_align_ctrl: RTL and testbench
=====================================

Name: dw_word_align_ctrl

Overview:
Streaming word-alignment controller that sits directly upstream of the DW01_bsh rotator. It searches each incoming word for a fixed sync pattern under every left rotation and confirms the pattern recurs once per frame. It then drives the rotator's SH input so that the rotator output is word-aligned. Data is forwarded with one register stage, so each data_out word and its sh value reach the rotator on the same cycle.

Parameters:
W, 8, data word width; must equal the downstream rotator's A_width.
SH_W, 3, shift-control width; must satisfy W <= 2**SH_W.
SYNC, 8'hB8, W-bit sync pattern; must have W distinct rotations.
FRAME_LEN, 16, words per frame, sync word included (>= 2).
VERIFY_CNT, 3, consecutive on-time sync hits needed to declare lock, counting the hunt hit (>= 1).
LOSS_CNT, 4, consecutive on-time sync misses that drop lock (>= 1).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
data_in  in  W  raw unaligned word.
data_valid  in  1  data_in valid this cycle.
data_out  out  W  data_in delayed one cycle; goes to the rotator's A input.
out_valid  out  1  data_valid delayed one cycle.
sh  out  SH_W  rotate-left amount; goes to the rotator's SH input. Always < W.
sof  out  1  start-of-frame pulse, aligned with data_out, asserted only while locked.
locked  out  1  high in the LOCK state.

Behaviour:
- Match function: hit(k) is true when rotl(data_in, k) == SYNC, for k = 0..W-1. rotl matches the rotator exactly: upper W bits of {A,A} << k.
- Reset (asynchronous assert, synchronous release):
  - Outputs: data_out = 0, out_valid = 0, sh = 0, sof = 0, locked = 0.
  - Internal: state = HUNT, frm_cnt = 0, hit_cnt = 0, miss_cnt = 0.
  - Reset mid-frame or mid-verify discards all progress.
- Pipeline: on every edge, data_out <= data_in and out_valid <= data_valid. Latency is 1 cycle, throughput is 1 word per cycle.
- When data_valid = 0: state, counters and sh hold; sof = 0.
- frm_cnt: counts valid words modulo FRAME_LEN. The check word is the valid word arriving when frm_cnt == 0.
- State HUNT:
  - On each valid word, if any hit(k) is true: sh <= lowest matching k, frm_cnt <= 1, hit_cnt <= 1.
  - Go to LOCK if VERIFY_CNT == 1, otherwise go to VERIFY.
  - sh changes on the same edge that data_out captures the detecting word, so the rotator emits SYNC for that word.
- State VERIFY:
  - Check word with hit(sh): hit_cnt += 1. When hit_cnt reaches VERIFY_CNT, go to LOCK with miss_cnt = 0.
  - Check word without hit(sh): go to HUNT. sh holds, and that word is not re-evaluated as a hunt candidate.
  - Non-check words: sync hits are ignored.
- State LOCK:
  - locked = 1, registered on entry.
  - Check word with hit(sh): miss_cnt <= 0 and sof <= 1 on the next cycle, aligned with data_out.
  - Check word without hit(sh): miss_cnt += 1. When miss_cnt reaches LOSS_CNT, go to HUNT and clear locked on the same edge.
  - sh never changes while in LOCK. A sync pattern at a different rotation is ignored.
- sof is 0 outside LOCK. On a LOCK→HUNT transition, no sof is issued for the failing check word.
- Counters saturate and cannot wrap past their thresholds. frm_cnt wraps FRAME_LEN-1 → 0.

Test Plan:
- Reset: hold rst_n = 0 with random data -> all outputs 0 and state HUNT. Release -> out_valid follows data_valid with 1-cycle lag.
- Acquire: W=8, SYNC=B8. Send 0x17 every 16th valid word, with 0x00 filler -> sh = 3 on the edge after the first 0x17. locked rises on the edge after the 3rd 0x17. sof pulses with every later 0x17 on data_out.
- Verify failure: 0x17, then 15 fillers, then 0x00 at the check slot -> returns to HUNT, locked stays 0. A later 0x17 re-acquires with sh = 3.
- Lock loss: while locked, corrupt 3 consecutive check words and send a good 4th -> stays locked. Corrupt 4 consecutive -> locked drops on the 4th check edge, no sof for it.
- Stalls and decoys while locked: randomly deassert data_valid -> frame position and sof unaffected. Inject 0xC5 (needs k = 5) at a non-check slot -> ignored, sh stays 3.
- Async reset asserted mid-VERIFY -> immediate clear. After release, re-acquisition requires the full 3-hit sequence.

Source files
------------

// File: rtl/dw_word_align_ctrl.sv
// Word-alignment controller for a DW01_bsh rotator: hunts for SYNC under every
// left rotation, verifies it recurs once per frame, then holds the rotate amount.
module dw_word_align_ctrl #(
  parameter int unsigned W          = 8,
  parameter int unsigned SH_W       = 3,
  parameter logic [W-1:0] SYNC      = 8'hB8,
  parameter int unsigned FRAME_LEN  = 16,
  parameter int unsigned VERIFY_CNT = 3,
  parameter int unsigned LOSS_CNT   = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [W-1:0]    data_in,
  input  logic            data_valid,
  output logic [W-1:0]    data_out,
  output logic            out_valid,
  output logic [SH_W-1:0] sh,
  output logic            sof,
  output logic            locked
);

  localparam int unsigned FCW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned HCW = $clog2(VERIFY_CNT + 1);
  localparam int unsigned MCW = $clog2(LOSS_CNT + 1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} state_e;

  state_e          state_q, state_d;
  logic [FCW-1:0]  frm_cnt_q, frm_cnt_d, frm_next;
  logic [HCW-1:0]  hit_cnt_q, hit_cnt_d;
  logic [MCW-1:0]  miss_cnt_q, miss_cnt_d;
  logic [SH_W-1:0] sh_q, sh_d, hunt_k;
  logic [W-1:0]    data_q;
  logic            valid_q, sof_q, sof_d, locked_q, locked_d;
  logic            any_hit, sh_hit, is_check;

  // Same rotation the rotator performs: upper W bits of {A,A} << k.
  function automatic logic [W-1:0] rotl(input logic [W-1:0] a, input logic [SH_W-1:0] k);
    return (a << k) | (a >> (W - int'(k)));
  endfunction

  // Lowest rotation that maps the incoming word onto SYNC.
  always_comb begin
    any_hit = 1'b0;
    hunt_k  = '0;
    for (int k = int'(W) - 1; k >= 0; k--) begin
      if (rotl(data_in, SH_W'(k)) == SYNC) begin
        any_hit = 1'b1;
        hunt_k  = SH_W'(k);
      end
    end
  end

  assign sh_hit   = (rotl(data_in, sh_q) == SYNC);
  assign is_check = (frm_cnt_q == '0);
  assign frm_next = (frm_cnt_q == FCW'(FRAME_LEN - 1)) ? '0 : frm_cnt_q + FCW'(1);

  always_comb begin
    state_d    = state_q;
    frm_cnt_d  = frm_cnt_q;
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    sh_d       = sh_q;
    sof_d      = 1'b0;
    locked_d   = locked_q;
    if (data_valid) begin
      frm_cnt_d = frm_next;
      unique case (state_q)
        HUNT: begin
          if (any_hit) begin
            sh_d      = hunt_k;
            frm_cnt_d = FCW'(1);
            hit_cnt_d = HCW'(1);
            if (VERIFY_CNT == 1) begin
              state_d    = LOCK;
              miss_cnt_d = '0;
              locked_d   = 1'b1;
            end else begin
              state_d = VERIFY;
            end
          end
        end
        VERIFY: begin
          if (is_check) begin
            if (!sh_hit) begin
              state_d   = HUNT;
              hit_cnt_d = '0;
            end else if (hit_cnt_q >= HCW'(VERIFY_CNT - 1)) begin
              state_d    = LOCK;
              miss_cnt_d = '0;
              locked_d   = 1'b1;
            end else begin
              hit_cnt_d = hit_cnt_q + HCW'(1);
            end
          end
        end
        LOCK: begin
          if (is_check) begin
            if (sh_hit) begin
              miss_cnt_d = '0;
              sof_d      = 1'b1;
            end else if (miss_cnt_q >= MCW'(LOSS_CNT - 1)) begin
              state_d    = HUNT;
              miss_cnt_d = '0;
              hit_cnt_d  = '0;
              locked_d   = 1'b0;
            end else begin
              miss_cnt_d = miss_cnt_q + MCW'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HUNT;
      frm_cnt_q  <= '0;
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      sh_q       <= '0;
      sof_q      <= 1'b0;
      locked_q   <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      frm_cnt_q  <= frm_cnt_d;
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
      sh_q       <= sh_d;
      sof_q      <= sof_d;
      locked_q   <= locked_d;
      data_q     <= data_in;
      valid_q    <= data_valid;
    end
  end

  assign data_out  = data_q;
  assign out_valid = valid_q;
  assign sh        = sh_q;
  assign sof       = sof_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_dw_word_align_ctrl.sv
// Directed bench for dw_word_align_ctrl: acquisition, verify failure, lock loss,
// stalls/decoys and asynchronous reset mid-verify.
module tb_dw_word_align_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic [7:0] data_out;
  logic       out_valid;
  logic [2:0] sh;
  logic       sof;
  logic       locked;

  int n_chk  = 0;
  int n_fail = 0;

  dw_word_align_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_out   (data_out),
    .out_valid  (out_valid),
    .sh         (sh),
    .sof        (sof),
    .locked     (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic expect_o(input string tag, input logic [7:0] d, input logic ov,
                          input logic [2:0] s, input logic sf, input logic lk);
    chk({tag, ".data_out"}, 32'(data_out), 32'(d));
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(ov));
    chk({tag, ".sh"}, 32'(sh), 32'(s));
    chk({tag, ".sof"}, 32'(sof), 32'(sf));
    chk({tag, ".locked"}, 32'(locked), 32'(lk));
  endtask

  // Drive one cycle; outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic [7:0] d, input logic v);
    data_in    = d;
    data_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      step(8'h00, 1'b1);
      chk("fill.sof", 32'(sof), 32'd0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    data_in    = '0;
    data_valid = 1'b0;

    // Reset held with random traffic
    for (int i = 0; i < 3; i++) begin
      step(8'($urandom), 1'b1);
      expect_o("reset", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    step(8'h5A, 1'b1);
    expect_o("pipe_v", 8'h5A, 1'b1, 3'd0, 1'b0, 1'b0);
    step(8'h00, 1'b0);
    expect_o("pipe_nv", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);

    // Acquire: 0x17 needs rotate-left 3 to become 0xB8
    step(8'h17, 1'b1);
    expect_o("acq1", 8'h17, 1'b1, 3'd3, 1'b0, 1'b0);
    fill(15);
    step(8'h17, 1'b1);
    expect_o("acq2", 8'h17, 1'b1, 3'd3, 1'b0, 1'b0);
    fill(15);
    step(8'h17, 1'b1);
    expect_o("acq3", 8'h17, 1'b1, 3'd3, 1'b0, 1'b1);
    fill(15);
    step(8'h17, 1'b1);
    expect_o("sof1", 8'h17, 1'b1, 3'd3, 1'b1, 1'b1);

    // Stalls and a decoy at another rotation inside a locked frame
    fill(5);
    step(8'h00, 1'b0);
    expect_o("stall", 8'h00, 1'b0, 3'd3, 1'b0, 1'b1);
    step(8'h17, 1'b0);
    expect_o("stall_sync", 8'h17, 1'b0, 3'd3, 1'b0, 1'b1);
    step(8'hC5, 1'b1);
    expect_o("decoy", 8'hC5, 1'b1, 3'd3, 1'b0, 1'b1);
    fill(9);
    step(8'h17, 1'b1);
    expect_o("sof_stall", 8'h17, 1'b1, 3'd3, 1'b1, 1'b1);
    step(8'h00, 1'b0);
    expect_o("post_sof", 8'h00, 1'b0, 3'd3, 1'b0, 1'b1);
    fill(15);

    // Three misses then a good check word keeps lock
    for (int i = 0; i < 3; i++) begin
      step(8'h00, 1'b1);
      expect_o("miss3", 8'h00, 1'b1, 3'd3, 1'b0, 1'b1);
      fill(15);
    end
    step(8'h17, 1'b1);
    expect_o("recover", 8'h17, 1'b1, 3'd3, 1'b1, 1'b1);
    fill(15);

    // Four misses drop lock on the fourth check word
    for (int i = 0; i < 4; i++) begin
      step(8'h00, 1'b1);
      expect_o("miss4", 8'h00, 1'b1, 3'd3, 1'b0, (i < 3) ? 1'b1 : 1'b0);
      fill(15);
    end

    // Verify failure returns to hunt without locking
    step(8'h17, 1'b1);
    expect_o("vf_hit", 8'h17, 1'b1, 3'd3, 1'b0, 1'b0);
    fill(15);
    step(8'h00, 1'b1);
    expect_o("vf_miss", 8'h00, 1'b1, 3'd3, 1'b0, 1'b0);
    fill(3);

    // Re-acquire at rotation 5, then reset mid-verify
    step(8'hC5, 1'b1);
    expect_o("reacq1", 8'hC5, 1'b1, 3'd5, 1'b0, 1'b0);
    fill(15);
    step(8'hC5, 1'b1);
    expect_o("reacq2", 8'hC5, 1'b1, 3'd5, 1'b0, 1'b0);
    fill(4);
    #2;
    rst_n = 1'b0;
    #1;
    expect_o("async_rst", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    step(8'h00, 1'b1);
    rst_n = 1'b1;

    // Full three-hit sequence needed again after reset
    step(8'hC5, 1'b1);
    expect_o("post_rst1", 8'hC5, 1'b1, 3'd5, 1'b0, 1'b0);
    fill(15);
    step(8'hC5, 1'b1);
    expect_o("post_rst2", 8'hC5, 1'b1, 3'd5, 1'b0, 1'b0);
    fill(15);
    step(8'hC5, 1'b1);
    expect_o("post_rst3", 8'hC5, 1'b1, 3'd5, 1'b0, 1'b1);
    fill(15);
    step(8'hC5, 1'b1);
    expect_o("post_rst_sof", 8'hC5, 1'b1, 3'd5, 1'b1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
